// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
// Bytes written to TXDATA queue in a FIFO and are sent LSB first on tx_o.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] data_mem_address_i,
  input  logic [31:0] data_mem_in_data_i,
  input  logic        data_mem_WE_i,
  output logic [31:0] data_mem_out_data_o,
  output logic        tx_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [15:0] DivRst = (CLK_DIV == 0) ? 16'd1 : 16'(CLK_DIV);

  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegDiv    = 2'd2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Bus decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_div;

  assign hit       = (data_mem_address_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = data_mem_address_i[3:2];
  assign wr_txdata = data_mem_WE_i && hit && (reg_sel == RegTxData);
  assign wr_status = data_mem_WE_i && hit && (reg_sel == RegStatus);
  assign wr_div    = data_mem_WE_i && hit && (reg_sel == RegDiv);

  logic unused_bits;
  assign unused_bits = ^{data_mem_in_data_i[31:16], data_mem_address_i[1:0]};

  // FIFO
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [7:0]      head;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign head  = fifo_mem_q[rd_ptr_q];
  // A pop on the same edge frees the slot, so a write to a full FIFO still lands.
  assign push  = wr_txdata && (!full || pop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data_mem_in_data_i[7:0];
    end
  end

  // Control registers
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_status && data_mem_in_data_i[3]) begin
      ovf_d = 1'b0;
    end
    div_d = div_q;
    if (wr_div) begin
      div_d = (data_mem_in_data_i[15:0] == 16'd0) ? 16'd1 : data_mem_in_data_i[15:0];
    end
  end

  // Transmit FSM
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] frame_div_q, frame_div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy;

  assign busy = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    frame_div_d = frame_div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop         = 1'b1;
          shift_d     = head;
          frame_div_d = div_q;
          timer_d     = div_q - 16'd1;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (timer_q == 16'd0) begin
          timer_d   = frame_div_q - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StData: begin
        if (timer_q == 16'd0) begin
          timer_d = frame_div_q - 16'd1;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StStop: begin
        if (timer_q == 16'd0) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (!empty) begin
            pop         = 1'b1;
            shift_d     = head;
            frame_div_d = div_q;
            timer_d     = div_q - 16'd1;
            state_d     = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is registered from the next state to keep tx_o glitch-free.
  always_comb begin
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Read data path: sampled from pre-write state of the presented address
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  count_ext;

  assign count_ext = 5'(count_q);

  always_comb begin
    rdata_d = 32'd0;
    if (hit) begin
      unique case (reg_sel)
        RegStatus: rdata_d = {23'd0, count_ext, ovf_q, busy, empty, full};
        RegDiv:    rdata_d = {16'd0, div_q};
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      div_q       <= DivRst;
      state_q     <= StIdle;
      timer_q     <= 16'd0;
      frame_div_q <= DivRst;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      tx_q        <= 1'b1;
      rdata_q     <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      div_q       <= div_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_div_q <= frame_div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rdata_q     <= rdata_d;
    end
  end

  assign tx_o                = tx_q;
  assign data_mem_out_data_o = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, serial receiver
// with an expected-byte scoreboard, and hand-written multi-cycle sequences.
module tb_mmio_uart_tx;

  localparam logic [31:0] Base = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        tx_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned div_model = 16;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  mmio_uart_tx #(
    .BASE_ADDR (Base),
    .CLK_DIV   (16),
    .FIFO_DEPTH(8)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .data_mem_address_i (addr),
    .data_mem_in_data_i (wdata),
    .data_mem_WE_i      (we),
    .data_mem_out_data_o(rdata),
    .tx_o               (tx_o)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.name = name; v.addr = a; v.we = w; v.wdata = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    addr = a; wdata = d; we = 1'b1;
    @(posedge CLK);
    if (a == Base + 32'h8) div_model = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
    #1 we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK);
    addr = a; we = 1'b0;
    @(negedge CLK);
    d = rdata;
  endtask

  task automatic wait_drain(input int unsigned max_cyc, input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Serial receiver: mid-bit sampling, bit period taken from the model at start-bit time.
  initial begin : rx_mon
    int unsigned d;
    int unsigned idx;
    logic [7:0]  b;
    logic [7:0]  e;
    logic        start_ok;
    logic        stop_ok;
    bit          aborted;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1 && tx_o === 1'b0) begin
        d = div_model;
        start_q.push_back(cyc);
        aborted = 1'b0; b = 8'd0; start_ok = 1'b1; stop_ok = 1'b0;
        for (int unsigned k = 1; k <= 9 * d + d / 2; k++) begin
          @(negedge CLK);
          if (RST !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (k % d == d / 2) begin
            idx = k / d;
            if (idx == 0) start_ok = (tx_o === 1'b0);
            else if (idx <= 8) b[3'(idx - 1)] = tx_o;
            else stop_ok = (tx_o === 1'b1);
          end
        end
        if (!aborted) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rx_unexpected: got byte 0x%02h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e || !start_ok || !stop_ok) begin
              n_err++;
              $display("FAIL rx_byte: got 0x%02h start_ok=%0d stop_ok=%0d, expected 0x%02h framed",
                       b, start_ok, stop_ok, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd;
    logic [7:0]  a5;
    logic        exp_bit;
    int unsigned c_m;
    int unsigned lows;

    // Reset values
    #2 RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("rst_tx", {31'd0, tx_o}, 32'd1);
      check("rst_rdata", rdata, 32'd0);
    end
    RST = 1'b1;

    // Register-map vectors (FIFO stays empty throughout)
    add_vec("st_reset",         Base + 32'h4,  1'b0, 32'd0,          32'h0000_0002);
    add_vec("div_reset",        Base + 32'h8,  1'b0, 32'd0,          32'd16);
    add_vec("txdata_rd",        Base,          1'b0, 32'd0,          32'd0);
    add_vec("rsvd_wr",          Base + 32'hC,  1'b1, 32'hFFFF_FFFF,  32'd0);
    add_vec("outside_wr",       Base + 32'h10, 1'b1, 32'h0000_1234,  32'd0);
    add_vec("other_base_push",  32'h0000_2000, 1'b1, 32'h0000_0055,  32'd0);
    add_vec("div_wr0_rdw",      Base + 32'h8,  1'b1, 32'd0,          32'd16);
    add_vec("div_zero_as_one",  Base + 32'h8,  1'b0, 32'd0,          32'd1);
    add_vec("div_wr_rdw",       Base + 32'h8,  1'b1, 32'hABCD_0007,  32'd1);
    add_vec("div_upper_masked", Base + 32'h8,  1'b0, 32'd0,          32'd7);
    add_vec("outside_rd",       Base + 32'h10, 1'b0, 32'd0,          32'd0);
    add_vec("rsvd_rd",          Base + 32'hC,  1'b0, 32'd0,          32'd0);
    add_vec("st_after_decode",  Base + 32'h4,  1'b0, 32'd0,          32'h0000_0002);
    add_vec("st_clr_no_ovf",    Base + 32'h4,  1'b1, 32'h0000_0008,  32'h0000_0002);
    add_vec("st_unchanged",     Base + 32'h4,  1'b0, 32'd0,          32'h0000_0002);
    add_vec("div_restore",      Base + 32'h8,  1'b1, 32'd16,         32'd7);
    add_vec("div_restored",     Base + 32'h8,  1'b0, 32'd0,          32'd16);
    add_vec("txdata_rd_idle",   Base,          1'b0, 32'd0,          32'd0);
    foreach (vecs[i]) begin
      addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].wdata;
      @(negedge CLK);
      check(vecs[i].name, rdata, vecs[i].exp);
    end
    we = 1'b0;
    div_model = 16;

    // Single byte 0xA5 at DIV=4, line checked cycle by cycle
    bus_write(Base + 32'h8, 32'd4);
    a5 = 8'hA5;
    @(negedge CLK);
    addr = Base; wdata = 32'h0000_00A5; we = 1'b1;
    exp_q.push_back(a5);
    @(negedge CLK);
    we = 1'b0; addr = Base + 32'h4;
    check("push_edge_tx_idle", {31'd0, tx_o}, 32'd1);
    @(negedge CLK);
    for (int i = 0; i < 40; i++) begin
      if (i < 4) exp_bit = 1'b0;
      else if (i >= 36) exp_bit = 1'b1;
      else exp_bit = a5[3'((i / 4) - 1)];
      check($sformatf("a5_line_c%0d", i), {31'd0, tx_o}, {31'd0, exp_bit});
      if (i == 0) check("st_at_pop_edge", rdata, 32'h0000_0010);
      if (i == 1) check("st_busy_empty", rdata, 32'h0000_0006);
      @(negedge CLK);
    end
    check("st_busy_last_stop", rdata, 32'h0000_0006);
    @(negedge CLK);
    check("st_busy_clear", rdata, 32'h0000_0002);
    wait_drain(100, "a5_drain");
    repeat (20) @(negedge CLK);

    // FIFO full, overflow, then push coinciding with a pop
    bus_write(Base + 32'h8, 32'd16);
    start_q.delete();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) exp_q.push_back(8'(i));
      bus_write(Base, 32'(i));
      if (i == 1) c_m = cyc;
    end
    bus_read(Base + 32'h4, rd);
    check("st_full_ovf", rd, 32'h0000_008D);
    bus_write(Base + 32'h4, 32'h0000_0008);
    bus_read(Base + 32'h4, rd);
    check("st_ovf_cleared", rd, 32'h0000_0085);
    while (cyc < c_m + 159) @(negedge CLK);
    exp_q.push_back(8'h0B);
    bus_write(Base, 32'h0000_000B);
    bus_read(Base + 32'h4, rd);
    check("st_push_pop_full", rd, 32'h0000_0085);
    wait_drain(2000, "burst_drain");
    repeat (20) @(negedge CLK);
    check("burst_frames", start_q.size(), 32'd10);
    for (int i = 0; i + 1 < start_q.size(); i++) begin
      check($sformatf("burst_gap%0d", i), start_q[i+1] - start_q[i], 32'd160);
    end

    // DIVISOR=0 written mid-frame: current frame keeps 16, later frames use 1
    start_q.delete();
    exp_q.push_back(8'h3C); bus_write(Base, 32'h0000_003C);
    exp_q.push_back(8'hC3); bus_write(Base, 32'h0000_00C3);
    exp_q.push_back(8'h5A); bus_write(Base, 32'h0000_005A);
    repeat (40) @(negedge CLK);
    bus_write(Base + 32'h8, 32'd0);
    bus_read(Base + 32'h8, rd);
    check("div_mid_frame", rd, 32'd1);
    wait_drain(400, "divchg_drain");
    repeat (20) @(negedge CLK);
    check("divchg_frames", start_q.size(), 32'd3);
    if (start_q.size() == 3) begin
      check("divchg_len_old", start_q[1] - start_q[0], 32'd160);
      check("divchg_len_new", start_q[2] - start_q[1], 32'd10);
    end

    // Reset asserted in the middle of a data bit
    bus_write(Base + 32'h8, 32'd16);
    bus_write(Base, 32'h0000_0011);
    bus_write(Base, 32'h0000_0022);
    bus_write(Base, 32'h0000_0033);
    repeat (40) @(negedge CLK);
    check("pre_rst_tx_low", {31'd0, tx_o}, 32'd0);
    #2 RST = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx_o}, 32'd1);
    check("rst_async_rdata", rdata, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    div_model = 16;
    bus_read(Base + 32'h4, rd);
    check("st_after_rst", rd, 32'h0000_0002);
    bus_read(Base + 32'h8, rd);
    check("div_after_rst", rd, 32'd16);
    lows = 0;
    repeat (200) begin
      @(negedge CLK);
      if (tx_o !== 1'b1) lows++;
    end
    check("no_resume_after_rst", lows, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus, alongside the data RAM. The CPU writes bytes into an internal FIFO through a small register window, and the block serializes them 8N1, LSB first, on `tx_o`. The CPU polls status and programs the bit period over the same address, write-data, write-enable and read-data interface it uses for RAM.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_1000: window base; the block decodes when `data_mem_address_i[31:4] == BASE_ADDR[31:4]`.
- `CLK_DIV`, default 16: reset value of the divisor register, in clocks per serial bit.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, 2..16.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `data_mem_address_i`  in  32: CPU byte address; word-decoded on bits [3:2].
- `data_mem_in_data_i`  in  32: CPU write data.
- `data_mem_WE_i`  in  1: write strobe, sampled on the rising edge of `CLK`.
- `data_mem_out_data_o`  out  32: registered read data.
- `tx_o`  out  1: serial output; idles high.

## Operation
Register map (offset from the base):
- 0x0 TXDATA.
  - Write: pushes `data_mem_in_data_i[7:0]` into the FIFO.
  - Read: returns 0.
- 0x4 STATUS (read):
  - bit0 full; bit1 empty; bit2 busy (FSM not in IDLE); bit3 overflow (sticky).
  - bits[8:4] FIFO count; all other bits 0.
  - Write with bit3=1 clears overflow. No other effect.
- 0x8 DIVISOR: read/write, bits[15:0]. A written value of 0 is stored as 1. Bits[31:16] read 0.
- 0xC: reserved. Reads return 0; writes are ignored.

Address and write behaviour:
- Addresses outside the window: writes are ignored and read data is 0.
- Write to TXDATA while the FIFO is full: the byte is dropped, overflow is set, and the FIFO is unchanged.

Transmit FSM (states IDLE, START, DATA, STOP):
- IDLE:
  - `tx_o`=1.
  - If the FIFO is non-empty: pop the head into the shift register, latch DIVISOR into the bit timer, then go to START.
- START: `tx_o`=0 for DIV clocks, then DATA with bit index 0.
- DATA:
  - `tx_o`=shift[0] for DIV clocks, then shift right.
  - After bit index 7, go to STOP.
- STOP: `tx_o`=1 for DIV clocks. At the end of STOP:
  - If the FIFO is non-empty, pop and go directly to START, with no extra idle cycle.
  - Otherwise go to IDLE.

Arithmetic and reset:
- Bit timer: 16-bit down-counter loaded with DIV−1; each bit ends on the cycle it reaches 0.
- A DIVISOR write mid-frame affects only the next frame.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. The count is one bit wider.
- A push and a pop on the same edge are both performed and the count is unchanged. This includes push-while-full coinciding with a pop: the push is accepted and overflow is not set.
- Reset asserted, including mid-frame, immediately forces:
  - `tx_o`=1 and `data_mem_out_data_o`=0;
  - FIFO empty (count 0);
  - overflow=0, DIVISOR=`CLK_DIV`, FSM in IDLE.
- No partial frame is resumed after reset.

## Timing
- Write effect: registers and FIFO update on the rising edge where `data_mem_WE_i`=1.
- Read latency: 1 clock. `data_mem_out_data_o` is loaded on every edge from the currently presented address, matching the RAM read latency.
- Read-during-write to the same register returns the pre-write value.
- First byte after an empty FIFO:
  - pushed on edge n;
  - popped on edge n+1;
  - `tx_o` falls after edge n+1;
  - STATUS empty reads 0 for the address presented at edge n+1.
- Frame length: exactly 10×DIV clocks. Back-to-back frames are contiguous.
- Busy is 1 from the pop edge until the edge that enters IDLE.

## Test plan
- **Reset values:** hold `RST`=0 for 3 clocks.
  - `tx_o`=1 and `data_mem_out_data_o`=0.
  - Then read STATUS: 0x0000_0002. Read DIVISOR: 16.
- **Single byte, DIV=4:** write 4 to 0x8, then write 0xA5 to 0x0.
  - Line sequence: `tx_o` low for 4 clocks, then 1,0,1,0,0,1,0,1, 4 clocks each.
  - Stop bit high for 4 clocks, then busy=0 at 40 clocks after the pop.
- **FIFO full and overflow, DIV=16:** write 10 bytes 0x01..0x0A back-to-back.
  - First pop at the second edge, so 8 stored; STATUS full=1.
  - One byte dropped and overflow=1.
  - Received stream is 0x01..0x09 with no idle gaps.
  - Writing 0x8 to STATUS clears overflow.
- **Simultaneous push and pop:** with the FIFO full, write TXDATA on the edge STOP ends.
  - The write is accepted, count stays 8, and overflow stays 0.
- **Mid-frame events:**
  - Write DIVISOR=0 during DATA: the current frame keeps its bit period, and the next frame uses DIV=1 (10-clock frame).
  - Assert `RST` mid-DATA: `tx_o`=1 immediately and the FIFO is empty.
- **Decode:** write to BASE_ADDR+0x10 and to 0xC.
  - No state change.
  - Reads of both addresses, and of TXDATA, return 0.
